// File: rtl/alu_stage.sv
// alu_stage
//   ALU stage fed by the shifter. It computes ADD/SUB/AND/NOT on the A operand
//   and the shifted B operand, with Z/N/V flags. Each result and its flags go
//   into a 2-entry in-order FIFO that the writeback stage reads with
//   valid/ready. A status register keeps the flags of the most recent
//   operation accepted with loads=1.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   ain, bin   A operand, shifted B operand
//   alu_op     00 ADD, 01 SUB, 10 AND, 11 NOT (~bin)
//   loads      update status with this operation's flags on accept
//   in_valid   operation valid       / in_ready  stage can accept
//   out_valid  FIFO head is valid    / out_ready consumer takes head
//   out_data   head result, out_flags head {Z,N,V}
//   status     architectural {Z,N,V}
module alu_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [1:0]       alu_op,
    input  logic             loads,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_flags,
    output logic [2:0]       status
);

    localparam int MSB = WIDTH - 1;
    localparam int EW  = WIDTH + 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_NOT = 2'b11
    } alu_op_e;

    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    logic [EW-1:0]    mem [2];
    logic [EW-1:0]    last_pop;
    logic [EW-1:0]    head;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             pop;

    always_comb begin
        result = '0;
        flag_v = 1'b0;
        case (alu_op_e'(alu_op))
            OP_ADD: begin
                result = ain + bin;
                flag_v = (ain[MSB] == bin[MSB]) && (result[MSB] != ain[MSB]);
            end
            OP_SUB: begin
                result = ain - bin;
                flag_v = (ain[MSB] != bin[MSB]) && (result[MSB] != ain[MSB]);
            end
            OP_AND: result = ain & bin;
            OP_NOT: result = ~bin;
            default: result = '0;
        endcase
        flag_z = (result == '0);
        flag_n = result[MSB];
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count < 2'd2) && reset_n;
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // With the FIFO empty the outputs hold the last popped entry rather than
    // whatever stale slot the read pointer now points at.
    assign head      = out_valid ? mem[rd_ptr] : last_pop;
    assign out_data  = head[EW-1:3];
    assign out_flags = head[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            last_pop <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            status   <= 3'b000;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {result, flag_z, flag_n, flag_v};
                wr_ptr      <= ~wr_ptr;
                if (loads) begin
                    status <= {flag_z, flag_n, flag_v};
                end
            end
            if (pop) begin
                last_pop <= mem[rd_ptr];
                rd_ptr   <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;

    localparam int W    = 16;
    localparam int MAXS = 2 ** (W - 1) - 1;
    localparam int MINS = -(2 ** (W - 1));

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] ain, bin;
    logic [1:0]   alu_op;
    logic         loads, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   out_flags, status;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [W+2:0] m_q[$];
    logic [W+2:0] m_last;
    logic [2:0]   m_status;

    alu_stage #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .ain(ain), .bin(bin), .alu_op(alu_op),
        .loads(loads), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .status(status)
    );

    always #5 clk = ~clk;

    // Signed-integer view of the operation: overflow is "true result does not
    // fit in W-bit two's complement".
    function automatic logic [W+2:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        int sa, sb, sr;
        logic [W-1:0] r;
        logic vv;
        sa = int'($signed(a));
        sb = int'($signed(b));
        vv = 1'b0;
        case (op)
            2'd0: begin sr = sa + sb; r = W'(sr); vv = (sr > MAXS) || (sr < MINS); end
            2'd1: begin sr = sa - sb; r = W'(sr); vv = (sr > MAXS) || (sr < MINS); end
            2'd2: r = a & b;
            default: r = ~b;
        endcase
        return {r, (r == 0), r[W-1], vv};
    endfunction

    function automatic logic [W+2:0] exp_head();
        return (m_q.size() > 0) ? m_q[0] : m_last;
    endfunction

    // advance one clock, updating the model with what the DUT should do
    task automatic step();
        bit acc, pp;
        logic [W+2:0] e;
        acc = in_valid && reset_n && (m_q.size() < 2);
        pp  = out_ready && (m_q.size() > 0);
        e   = ref_alu(ain, bin, alu_op);
        if (pp) m_last = m_q.pop_front();
        if (acc) begin
            m_q.push_back(e);
            if (loads) m_status = e[2:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ain = '0; bin = '0; alu_op = '0; loads = 1'b0;
        m_q.delete(); m_last = '0; m_status = '0;
        #2;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            out_flags !== 3'b000 || status !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h flags=%b st=%b want 0/0/0000/000/000",
                     in_ready, out_valid, out_data, out_flags, status);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_alu_ops();
        logic [W-1:0] t_a  [5] = '{16'h7FFF, 16'h0799, 16'h8000, 16'hF0CF, 16'h1234};
        logic [W-1:0] t_b  [5] = '{16'h0001, 16'hF867, 16'h0001, 16'h0FF0, 16'hFFFF};
        logic [1:0]   t_op [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        logic         t_ld [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] t_r  [5] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h00C0, 16'h0000};
        logic [2:0]   t_f  [5] = '{3'b011, 3'b100, 3'b001, 3'b000, 3'b100};
        logic [2:0]   t_s  [5] = '{3'b011, 3'b100, 3'b100, 3'b000, 3'b100};
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1; ain = t_a[i]; bin = t_b[i]; alu_op = t_op[i]; loads = t_ld[i];
            step();
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== t_r[i] || out_flags !== t_f[i]) begin
                n_fail++;
                $display("FAIL alu_op[%0d]: got vld=%b data=%h flags=%b want 1/%h/%b",
                         i, out_valid, out_data, out_flags, t_r[i], t_f[i]);
            end
            n_tests++;
            if (status !== t_s[i]) begin
                n_fail++;
                $display("FAIL alu_status[%0d]: got %b want %b", i, status, t_s[i]);
            end
            out_ready = 1'b1;
            step();
            n_tests++;
            if (out_valid !== 1'b0 || out_data !== t_r[i] || out_flags !== t_f[i]) begin
                n_fail++;
                $display("FAIL empty_hold[%0d]: got vld=%b data=%h flags=%b want 0/%h/%b",
                         i, out_valid, out_data, out_flags, t_r[i], t_f[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] seq [3] = '{16'h0001, 16'h0002, 16'h0003};
        int k;
        bit acc_now;
        out_ready = 1'b0; alu_op = 2'd0; ain = '0; loads = 1'b0;
        in_valid = 1'b1; bin = 16'h0001; step();
        bin = 16'h0002; step();
        bin = 16'h0003;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0001) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b data=%h want 0/1/0001",
                         c, in_ready, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== seq[k]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got vld=%b data=%h want 1/%h",
                         k, out_valid, out_data, seq[k]);
            end
            k++;
            acc_now = in_valid && (m_q.size() < 2);
            step();
            if (acc_now) in_valid = 1'b0;
        end
        n_tests++;
        if (k != 3 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pops vld=%b want 3/0", k, out_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 11; c++) begin
            ain = W'($urandom); bin = W'($urandom);
            alu_op = 2'($urandom); loads = 1'($urandom);
            step();
            e = exp_head();
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || m_q.size() != 1 ||
                out_data !== e[W+2:3] || out_flags !== e[2:0]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got rdy=%b vld=%b data=%h flags=%b want 1/1/%h/%b",
                         c, in_ready, out_valid, out_data, out_flags, e[W+2:3], e[2:0]);
            end
        end
        drain();
    endtask

    task automatic test_random();
        logic [W+2:0] e;
        for (int c = 0; c < 400; c++) begin
            ain = W'($urandom); bin = W'($urandom);
            if (c % 7 == 0) bin = W'(-int'($signed(ain)));
            alu_op = 2'($urandom); loads = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            e = exp_head();
            n_tests++;
            if (in_ready !== (m_q.size() < 2) || out_valid !== (m_q.size() > 0) ||
                out_data !== e[W+2:3] || out_flags !== e[2:0] || status !== m_status) begin
                n_fail++;
                $display("FAIL random[%0d]: got rdy=%b vld=%b data=%h fl=%b st=%b want %b/%b/%h/%b/%b",
                         c, in_ready, out_valid, out_data, out_flags, status,
                         (m_q.size() < 2), (m_q.size() > 0), e[W+2:3], e[2:0], m_status);
            end
            step();
        end
        drain();
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0; in_valid = 1'b1;
        ain = 16'h7FFF; bin = 16'h0001; alu_op = 2'd0; loads = 1'b1;
        step();
        ain = 16'h0010; bin = 16'h0020; loads = 1'b0;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || status !== 3'b011 || out_data !== 16'h8000) begin
            n_fail++;
            $display("FAIL pre_reset: got rdy=%b st=%b data=%h want 0/011/8000",
                     in_ready, status, out_data);
        end
        #2;
        reset_n = 1'b0;
        m_q.delete(); m_last = '0; m_status = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_flags !== 3'b000 ||
            status !== 3'b000 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got vld=%b data=%h fl=%b st=%b rdy=%b want 0/0000/000/000/0",
                     out_valid, out_data, out_flags, status, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got rdy=%b vld=%b data=%h want 1/0/0000",
                         c, in_ready, out_valid, out_data);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
